// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe delay-line family.
package dff_pkg;

  // Polarity selectors for the EN_ACT_LOW parameter of dff_pipe.
  localparam bit EN_ACT_HIGH = 1'b0;
  localparam bit EN_ACT_LOW  = 1'b1;

  // Width of an in-flight counter that must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data register plus its valid bit.
module dff_stage #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Flush only clears validity; data keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      data_q  <= d;
      valid_q <= in_valid;
    end
  end

  assign q       = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// Stallable DEPTH-stage delay line with per-stage valid and synchronous flush.
// Define DFF_PIPE_OCC_EN to add the occ in-flight entry counter port.
module dff_pipe #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter bit               EN_ACT_LOW = dff_pkg::EN_ACT_HIGH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     flush,
  input  logic                                     in_valid,
  input  logic [WIDTH-1:0]                         d,
`ifdef DFF_PIPE_OCC_EN
  output logic [dff_pkg::occ_width(DEPTH)-1:0]     occ,
`endif
  output logic [WIDTH-1:0]                         q,
  output logic                                     q_valid
);

  if (DEPTH < 1) begin : g_depth_check
    $error("dff_pipe: DEPTH must be at least 1");
  end

  logic                 adv;
  logic [WIDTH-1:0]     data [DEPTH];
  logic [DEPTH-1:0]     valid;

  assign adv = (EN_ACT_LOW == dff_pkg::EN_ACT_LOW) ? ~en : en;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] stage_d;
    logic             stage_v;

    if (i == 0) begin : g_head
      assign stage_d = d;
      assign stage_v = in_valid;
    end else begin : g_body
      assign stage_d = data[i-1];
      assign stage_v = valid[i-1];
    end

    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .adv      (adv),
      .in_valid (stage_v),
      .d        (stage_d),
      .q        (data[i]),
      .q_valid  (valid[i])
    );
  end

  assign q       = data[DEPTH-1];
  assign q_valid = valid[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OccW = dff_pkg::occ_width(DEPTH);

  logic [OccW-1:0] occ_q, occ_d;

  // Modular arithmetic is safe: a full pipe always retires when it accepts.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (adv) begin
      occ_d = occ_q + OccW'(in_valid) - OccW'(valid[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

`ifndef SYNTHESIS
  occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
    int'(occ_q) == $countones(valid));
`endif
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: active-high and active-low enable copies, plus DEPTH=1.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [7:0] d = 8'h00;
  logic       en_n;
  logic [7:0] q_a, q_b;
  logic       qv_a, qv_b;

  logic       rst1 = 1'b1, en1 = 1'b0, flush1 = 1'b0, iv1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic [7:0] q_c;
  logic       qv_c;

`ifdef DFF_PIPE_OCC_EN
  logic [2:0] occ_a, occ_b;
  logic       occ_c;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  assign en_n = ~en;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5), .EN_ACT_LOW(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .d(d),
`ifdef DFF_PIPE_OCC_EN
    .occ(occ_a),
`endif
    .q(q_a), .q_valid(qv_a)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5), .EN_ACT_LOW(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en_n), .flush(flush), .in_valid(in_valid), .d(d),
`ifdef DFF_PIPE_OCC_EN
    .occ(occ_b),
`endif
    .q(q_b), .q_valid(qv_b)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .EN_ACT_LOW(1'b0)) u_c (
    .clk(clk), .rst(rst1), .en(en1), .flush(flush1), .in_valid(iv1), .d(d1),
`ifdef DFF_PIPE_OCC_EN
    .occ(occ_c),
`endif
    .q(q_c), .q_valid(qv_c)
  );

  typedef struct {
    logic       rst, en, flush, iv;
    logic [7:0] d;
    logic [7:0] exp_q;
    logic       exp_qv;
    int         exp_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, e, f, v, input logic [7:0] dd,
                              input logic [7:0] eq, input logic eqv, input int eo);
    vec_t t;
    t.rst = r; t.en = e; t.flush = f; t.iv = v; t.d = dd;
    t.exp_q = eq; t.exp_qv = eqv; t.exp_occ = eo;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic c_step(input logic r, e, f, v, input logic [7:0] dd,
                        input logic [7:0] eq, input logic eqv, input int eo, input string nm);
    @(negedge clk);
    rst1 = r; en1 = e; flush1 = f; iv1 = v; d1 = dd;
    @(posedge clk);
    #1;
    check({nm, " q"}, 32'(q_c), 32'(eq));
    check({nm, " q_valid"}, 32'(qv_c), 32'(eqv));
`ifdef DFF_PIPE_OCC_EN
    check({nm, " occ"}, 32'(occ_c), 32'(eo));
`endif
  endtask

  initial begin
    // Reset, then a back-to-back stream 11..55 with 4-edge latency.
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h11, 8'hA5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'h22, 8'hA5, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 8'h33, 8'hA5, 0, 3));
    vecs.push_back(mk(0, 1, 0, 1, 8'h44, 8'h11, 1, 4));
    vecs.push_back(mk(0, 1, 0, 1, 8'h55, 8'h22, 1, 4));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h33, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h44, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h55, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    // Load two, stall three cycles with in_valid pulses that must be dropped.
    vecs.push_back(mk(0, 1, 0, 1, 8'h11, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'h22, 8'h00, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 8'h77, 8'h00, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 8'h78, 8'h00, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 8'h79, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 8'h5A, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 8'h5A, 8'h11, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 8'h5A, 8'h22, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 8'h5A, 8'h5A, 0, 0));
    // Three in flight, then flush while presenting 0x99.
    vecs.push_back(mk(0, 1, 0, 1, 8'hAA, 8'h5A, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'hBB, 8'h5A, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 8'hCC, 8'h5A, 0, 3));
    vecs.push_back(mk(0, 1, 1, 1, 8'h99, 8'h5A, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hAA, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hBB, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hCC, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    // Fill all four stages, then reset together with flush and en.
    vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h00, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 8'h03, 8'h00, 0, 3));
    vecs.push_back(mk(0, 1, 0, 1, 8'h04, 8'h01, 1, 4));
    vecs.push_back(mk(1, 1, 1, 1, 8'hEE, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'hA5, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hA5, 0, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; flush = vecs[i].flush;
      in_valid = vecs[i].iv; d = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("row%0d a.q", i), 32'(q_a), 32'(vecs[i].exp_q));
      check($sformatf("row%0d a.q_valid", i), 32'(qv_a), 32'(vecs[i].exp_qv));
      check($sformatf("row%0d b.q", i), 32'(q_b), 32'(vecs[i].exp_q));
      check($sformatf("row%0d b.q_valid", i), 32'(qv_b), 32'(vecs[i].exp_qv));
`ifdef DFF_PIPE_OCC_EN
      check($sformatf("row%0d a.occ", i), 32'(occ_a), 32'(vecs[i].exp_occ));
      check($sformatf("row%0d b.occ", i), 32'(occ_b), 32'(vecs[i].exp_occ));
`endif
    end

    // DEPTH=1: single register, bubble data visible but unqualified.
    c_step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, "d1 reset");
    c_step(0, 1, 0, 1, 8'h01, 8'h01, 1, 1, "d1 load01");
    c_step(0, 1, 0, 0, 8'h02, 8'h02, 0, 0, "d1 bubble02");
    c_step(0, 1, 0, 1, 8'h03, 8'h03, 1, 1, "d1 load03");
    c_step(0, 0, 0, 1, 8'h04, 8'h03, 1, 1, "d1 hold");
    c_step(0, 1, 1, 1, 8'h05, 8'h03, 0, 0, "d1 flush");
    c_step(0, 1, 0, 1, 8'h06, 8'h06, 1, 1, "d1 resume");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
